// File: rtl/recording_readout_if.sv
// Byte-stream output channel of the recording readout framer.
// Master drives a frame byte with valid/last; slave accepts with ready.
interface recording_readout_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/recording_readout.sv
// Frames one captured recording (header, timestamp, length, samples, XOR checksum)
// from the channel FIFO onto a valid/ready byte stream.
//
//   state | meaning
//   IDLE  | waiting for echo_pulse_detected; ts/len latched on the pulse
//   HDR   | presenting sync byte HDR_BYTE
//   TS_H  | presenting timestamp high byte
//   TS_L  | presenting timestamp low byte
//   LEN_H | presenting sample length high byte
//   LEN_L | presenting sample length low byte
//   DATA  | streaming len samples through the 2-entry skid buffer
//   CSUM  | presenting XOR checksum with m_last
module recording_readout #(
  parameter int         DATA_W   = 8,
  parameter int         LEN_W    = 13,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              echo_pulse_detected,
  input  logic [LEN_W-1:0]  sample_length,
  input  logic [LEN_W-1:0]  timestamp,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              busy,
  output logic              overrun,
  recording_readout_if.master m
);

  typedef enum logic [2:0] {
    IDLE, HDR, TS_H, TS_L, LEN_H, LEN_L, DATA, CSUM
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  ts_q, len_q;
  logic [LEN_W-1:0]  rd_left_q, xfer_left_q;
  logic [DATA_W-1:0] skid0_q, skid1_q;
  logic [1:0]        skid_cnt_q;
  logic              inflight_q;
  logic [7:0]        csum_q;
  logic              overrun_q;
  logic              pop;
  logic              xfer;
  logic [2:0]        occ;
  logic [15:0]       ts_ext, len_ext;

  assign ts_ext  = 16'(ts_q);
  assign len_ext = 16'(len_q);
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;
  assign xfer    = m.m_valid && m.m_ready;

  always_comb begin
    state_d    = state_q;
    m.m_valid  = 1'b0;
    m.m_data   = '0;
    m.m_last   = 1'b0;
    fifo_rdreq = 1'b0;
    pop        = 1'b0;
    occ        = '0;
    case (state_q)
      IDLE: begin
        if (echo_pulse_detected) state_d = HDR;
      end
      HDR: begin
        m.m_valid = 1'b1;
        m.m_data  = HDR_BYTE;
        if (m.m_ready) state_d = TS_H;
      end
      TS_H: begin
        m.m_valid = 1'b1;
        m.m_data  = ts_ext[15:8];
        if (m.m_ready) state_d = TS_L;
      end
      TS_L: begin
        m.m_valid = 1'b1;
        m.m_data  = ts_ext[7:0];
        if (m.m_ready) state_d = LEN_H;
      end
      LEN_H: begin
        m.m_valid = 1'b1;
        m.m_data  = len_ext[15:8];
        if (m.m_ready) state_d = LEN_L;
      end
      LEN_L: begin
        m.m_valid = 1'b1;
        m.m_data  = len_ext[7:0];
        if (m.m_ready) state_d = (len_q != '0) ? DATA : CSUM;
      end
      DATA: begin
        m.m_valid = (skid_cnt_q != 2'd0);
        m.m_data  = 8'(skid0_q);
        pop       = m.m_valid && m.m_ready;
        // Occupancy net of this cycle's pop keeps the pipe full at one byte per cycle.
        occ        = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(pop);
        fifo_rdreq = !fifo_empty && (rd_left_q != '0) && (occ < 3'd2);
        if (pop && (xfer_left_q == LEN_W'(1))) state_d = CSUM;
      end
      CSUM: begin
        m.m_valid = 1'b1;
        m.m_last  = 1'b1;
        m.m_data  = csum_q;
        if (m.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ts_q        <= '0;
      len_q       <= '0;
      rd_left_q   <= '0;
      xfer_left_q <= '0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_cnt_q  <= 2'd0;
      inflight_q  <= 1'b0;
      csum_q      <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rdreq;
      if (state_q == IDLE && echo_pulse_detected) begin
        ts_q        <= timestamp;
        len_q       <= sample_length;
        rd_left_q   <= sample_length;
        xfer_left_q <= sample_length;
        csum_q      <= 8'd0;
      end
      if (busy && echo_pulse_detected) overrun_q <= 1'b1;
      if (xfer && state_q != CSUM) csum_q <= csum_q ^ m.m_data;
      if (fifo_rdreq) rd_left_q <= rd_left_q - LEN_W'(1);
      if (pop) xfer_left_q <= xfer_left_q - LEN_W'(1);
      // Push from the read issued last cycle; pop toward the head.
      case ({inflight_q, pop})
        2'b10: begin
          if (skid_cnt_q == 2'd0) skid0_q <= fifo_q;
          else skid1_q <= fifo_q;
          skid_cnt_q <= skid_cnt_q + 2'd1;
        end
        2'b01: begin
          skid0_q    <= skid1_q;
          skid_cnt_q <= skid_cnt_q - 2'd1;
        end
        2'b11: begin
          if (skid_cnt_q == 2'd2) begin
            skid0_q <= skid1_q;
            skid1_q <= fifo_q;
          end else begin
            skid0_q <= fifo_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recording_readout.sv
// Directed bench for recording_readout: FIFO model, byte monitor and
// hand-computed frames covering backpressure, overrun, reset abort and FIFO stalls.
module tb_recording_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        echo;
  logic [12:0] sample_length;
  logic [12:0] timestamp;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        fifo_rdreq;
  logic        busy;
  logic        overrun;
  logic        force_empty;

  recording_readout_if bus ();

  recording_readout #(.DATA_W(8), .LEN_W(13), .HDR_BYTE(8'hA5)) dut (
    .clk                 (clk),
    .reset               (reset),
    .echo_pulse_detected (echo),
    .sample_length       (sample_length),
    .timestamp           (timestamp),
    .fifo_empty          (fifo_empty),
    .fifo_q              (fifo_q),
    .fifo_rdreq          (fifo_rdreq),
    .busy                (busy),
    .overrun             (overrun),
    .m                   (bus.master)
  );

  always #5 clk = ~clk;

  // Normal-mode FIFO: data appears the cycle after the read request.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rdreq) begin
      fifo_q <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor, sampled on the falling edge where all signals are settled.
  logic [7:0] out_b   [0:1023];
  logic       out_l   [0:1023];
  int         out_cyc [0:1023];
  int out_cnt  = 0;
  int rd_count = 0;
  int empty_rd = 0;
  int cyc      = 0;

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      out_b[out_cnt % 1024]   = bus.m_data;
      out_l[out_cnt % 1024]   = bus.m_last;
      out_cyc[out_cnt % 1024] = cyc;
      out_cnt++;
    end
    if (fifo_rdreq) rd_count++;
    if (fifo_rdreq && force_empty) empty_rd++;
    cyc++;
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_b [0:299];
  int exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic start_frame(input logic [12:0] ts, input logic [12:0] len);
    echo = 1'b1;
    timestamp = ts;
    sample_length = len;
    @(posedge clk); #1;
    echo = 1'b0;
  endtask

  task automatic set_hdr(input logic [12:0] ts, input logic [12:0] len);
    exp_n = 5 + int'(len) + 1;
    exp_b[0] = 8'hA5;
    exp_b[1] = {3'b000, ts[12:8]};
    exp_b[2] = ts[7:0];
    exp_b[3] = {3'b000, len[12:8]};
    exp_b[4] = len[7:0];
  endtask

  task automatic wait_bytes(input string tag, input int target, input bit toggle, input int limit);
    for (int c = 0; c < limit && out_cnt < target; c++) begin
      @(posedge clk); #1;
      if (toggle) bus.m_ready = ~bus.m_ready;
    end
    chk({tag, " reached"}, 32'(out_cnt >= target), 32'd1);
    bus.m_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int base);
    chk({tag, " count"}, 32'(out_cnt - base), 32'(exp_n));
    for (int i = 0; i < exp_n; i++)
      chk($sformatf("%s byte%0d", tag, i),
          {23'd0, out_l[(base + i) % 1024], out_b[(base + i) % 1024]},
          {23'd0, (i == exp_n - 1), exp_b[i]});
  endtask

  int base, rd_base, er_base;

  initial begin
    reset = 1'b1;
    echo = 1'b0;
    sample_length = '0;
    timestamp = '0;
    force_empty = 1'b0;
    bus.m_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdreq", 32'(fifo_rdreq), 32'd0);
    chk("rst valid", 32'(bus.m_valid), 32'd0);
    chk("rst last", 32'(bus.m_last), 32'd0);
    chk("rst data", 32'(bus.m_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);

    // Basic frame, echo in the first cycle after reset release.
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    @(posedge clk); #1;
    reset = 1'b0;
    base = out_cnt; rd_base = rd_count;
    start_frame(13'h0123, 13'd4);
    @(negedge clk);
    chk("t1 busy rise", 32'(busy), 32'd1);
    set_hdr(13'h0123, 13'd4);
    for (int i = 0; i < 4; i++) exp_b[5 + i] = 8'h10 + 8'(i);
    exp_b[9] = 8'h83;
    wait_bytes("t1", base + 10, 1'b0, 100);
    check_frame("t1", base);
    chk("t1 rdreq", 32'(rd_count - rd_base), 32'd4);
    @(negedge clk);
    chk("t1 busy fall", 32'(busy), 32'd0);

    // Zero-length frame.
    @(posedge clk); #1;
    base = out_cnt; rd_base = rd_count;
    start_frame(13'h1FFF, 13'd0);
    set_hdr(13'h1FFF, 13'd0);
    exp_b[5] = 8'h45;
    wait_bytes("t2", base + 6, 1'b0, 100);
    check_frame("t2", base);
    chk("t2 rdreq", 32'(rd_count - rd_base), 32'd0);

    // 256 samples with m_ready toggling every cycle.
    for (int i = 0; i < 256; i++) push(8'(i));
    @(posedge clk); #1;
    base = out_cnt; rd_base = rd_count;
    start_frame(13'h0ABC, 13'd256);
    set_hdr(13'h0ABC, 13'd256);
    for (int i = 0; i < 256; i++) exp_b[5 + i] = 8'(i);
    exp_b[261] = 8'h12;
    wait_bytes("t3", base + 262, 1'b1, 2000);
    check_frame("t3", base);
    chk("t3 rdreq", 32'(rd_count - rd_base), 32'd256);
    chk("t3 overrun", 32'(overrun), 32'd0);

    // Second echo mid-DATA: overrun, frame unchanged, no new frame; full-rate check.
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    @(posedge clk); #1;
    base = out_cnt; rd_base = rd_count;
    start_frame(13'h0042, 13'd8);
    wait_bytes("t4 mid", base + 8, 1'b0, 100);
    start_frame(13'h1111, 13'd3);
    set_hdr(13'h0042, 13'd8);
    for (int i = 0; i < 8; i++) exp_b[5 + i] = 8'h20 + 8'(i);
    exp_b[13] = 8'hEF;
    wait_bytes("t4", base + 14, 1'b0, 100);
    check_frame("t4", base);
    chk("t4 overrun", 32'(overrun), 32'd1);
    chk("t4 rdreq", 32'(rd_count - rd_base), 32'd8);
    chk("t4 latency", 32'(out_cyc[base + 5] - out_cyc[base + 4]), 32'd3);
    chk("t4 rate", 32'(out_cyc[base + 12] - out_cyc[base + 5]), 32'd7);
    repeat (10) @(posedge clk);
    #1;
    chk("t4 no 2nd frame", 32'(out_cnt - base), 32'd14);
    chk("t4 idle", 32'(busy), 32'd0);

    // Reset at sample 3 of 8 aborts the frame; a fresh frame follows.
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    @(posedge clk); #1;
    base = out_cnt;
    start_frame(13'h0100, 13'd8);
    wait_bytes("t5 mid", base + 8, 1'b0, 100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5 valid", 32'(bus.m_valid), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 rdreq", 32'(fifo_rdreq), 32'd0);
    chk("t5 overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    wr_ptr = rd_ptr;
    push(8'h55);
    push(8'hAA);
    base = out_cnt; rd_base = rd_count;
    start_frame(13'h0001, 13'd2);
    set_hdr(13'h0001, 13'd2);
    exp_b[5] = 8'h55;
    exp_b[6] = 8'hAA;
    exp_b[7] = 8'h59;
    wait_bytes("t5", base + 8, 1'b0, 100);
    check_frame("t5", base);
    chk("t5 new rdreq", 32'(rd_count - rd_base), 32'd2);

    // FIFO empty forced for 5 cycles mid-DATA.
    for (int i = 1; i <= 6; i++) push(8'(i));
    @(posedge clk); #1;
    base = out_cnt; rd_base = rd_count;
    start_frame(13'h0007, 13'd6);
    wait_bytes("t6 mid", base + 7, 1'b0, 100);
    er_base = empty_rd;
    force_empty = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("t6 valid drop", 32'(bus.m_valid), 32'd0);
    @(posedge clk); #1;
    force_empty = 1'b0;
    chk("t6 rdreq stalled", 32'(empty_rd - er_base), 32'd0);
    set_hdr(13'h0007, 13'd6);
    for (int i = 0; i < 6; i++) exp_b[5 + i] = 8'(i + 1);
    exp_b[11] = 8'hA3;
    wait_bytes("t6", base + 12, 1'b0, 100);
    check_frame("t6", base);
    chk("t6 rdreq", 32'(rd_count - rd_base), 32'd6);

    // Echo in the cycle the checksum byte transfers.
    @(posedge clk); #1;
    base = out_cnt;
    chk("t7 overrun pre", 32'(overrun), 32'd0);
    start_frame(13'h0000, 13'd0);
    repeat (5) @(posedge clk);
    #1;
    echo = 1'b1;
    @(negedge clk);
    chk("t7 in csum", 32'(bus.m_last && bus.m_valid), 32'd1);
    @(posedge clk); #1;
    echo = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t7 overrun", 32'(overrun), 32'd1);
    chk("t7 no frame", 32'(out_cnt - base), 32'd6);
    chk("t7 csum", 32'(out_b[(base + 5) % 1024]), 32'hA5);
    chk("t7 idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recording_readout.md
RECORDING_READOUT -- requirements
Module: recording_readout

Interface
REQ-001 Parameter DATA_W, default 8: FIFO sample width and output byte width.
REQ-002 Parameter LEN_W, default 13: width of sample_length and timestamp.
REQ-003 Parameter HDR_BYTE, default 8'hA5: frame sync byte.
REQ-004 clk  in  1  fast ADC-domain clock; all logic rising-edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 echo_pulse_detected  in  1  one-cycle pulse from the recording channel; a capture is complete in its FIFO.
REQ-007 sample_length  in  LEN_W  number of samples stored; valid in the echo_pulse_detected cycle.
REQ-008 timestamp  in  LEN_W  stop-pulse timestamp; valid in the echo_pulse_detected cycle.
REQ-009 fifo_empty  in  1  recording FIFO empty flag.
REQ-010 fifo_q  in  DATA_W  FIFO read data, normal (non-show-ahead) mode, valid 1 cycle after fifo_rdreq.
REQ-011 fifo_rdreq  out  1  FIFO read request.
REQ-012 m_data  out  8  output frame byte.
REQ-013 m_valid  out  1  m_data valid.
REQ-014 m_ready  in  1  downstream accept; a byte transfers on m_valid && m_ready.
REQ-015 m_last  out  1  marks the final (checksum) byte of a frame.
REQ-016 busy  out  1  high from frame capture until the last byte transfers.
REQ-017 overrun  out  1  sticky; echo pulse arrived while busy.

Function
REQ-018 Frame order: HDR_BYTE, {3'b0,ts[12:8]}, ts[7:0], {3'b0,len[12:8]}, len[7:0], len samples, checksum.
REQ-019 Checksum is the XOR of all preceding frame bytes, header included.
REQ-020 States: IDLE, HDR, TS_H, TS_L, LEN_H, LEN_L, DATA, CSUM.
REQ-021 In IDLE, echo_pulse_detected latches timestamp and sample_length and moves to HDR on the next cycle; busy rises in that same next cycle.
REQ-022 Each header state holds m_valid=1 with a constant byte until m_ready, then advances; no byte is dropped or duplicated under backpressure.
REQ-023 LEN_L goes to DATA if len>0, otherwise to CSUM.
REQ-024 DATA uses a 2-entry skid buffer; fifo_rdreq=1 only when !fifo_empty, requested count < len, and (buffer occupancy + in-flight reads) < 2.
REQ-025 With m_ready held high and FIFO non-empty, DATA sustains 1 byte per cycle after 2 cycles of initial latency.
REQ-026 DATA moves to CSUM when the len-th sample transfers; fifo_rdreq is never asserted beyond len reads per frame.
REQ-027 CSUM presents the checksum with m_last=1; on transfer, returns to IDLE and busy falls in the same cycle.
REQ-028 An echo_pulse_detected pulse while busy is ignored for framing and sets overrun=1 until reset.
REQ-029 An echo pulse in the same cycle the CSUM byte transfers counts as busy: it sets overrun and does not start a frame.
REQ-030 fifo_empty during DATA stalls reads only; m_valid drops when the skid buffer is empty; no timeout.
REQ-031 Counters are LEN_W bits wide; len = 2^LEN_W-1 (8191) is supported without wrap.

Reset
REQ-032 Reset applies when reset=1 at a clock edge and overrides all other inputs.
REQ-033 Reset values: state IDLE, fifo_rdreq=0, m_valid=0, m_last=0, m_data=0, busy=0, overrun=0; skid buffer and counters cleared.
REQ-034 Reset mid-frame aborts the frame with no checksum; FIFO contents are not drained by this block.
REQ-035 After reset deassertion, an echo pulse is accepted in the first cycle.

Verification
REQ-036 ts=0x0123, len=4, FIFO=10,11,12,13, m_ready=1 -> bytes A5,01,23,00,04,10,11,12,13,csum=0x83 (A5^01^23^04^10^11^12^13); m_last only on 0x83; exactly 4 rdreq.
REQ-037 len=0, ts=0x1FFF -> A5,1F,FF,00,00,csum=0x45; fifo_rdreq never asserted.
REQ-038 len=256 with m_ready toggling 1/0 per cycle -> all 256 bytes transfer in order, with no duplicates or drops; rdreq count = 256.
REQ-039 Second echo pulse during DATA -> overrun=1, current frame completes unchanged, and no second frame starts.
REQ-040 reset pulsed during DATA at sample 3 of 8 -> next cycle m_valid=0, busy=0, fifo_rdreq=0; a new echo pulse then produces a full, correct frame.
REQ-041 fifo_empty forced high for 5 cycles mid-DATA -> no rdreq during those cycles, stream resumes, and checksum is correct.
